// File: rtl/skolem_sweep_pkg.sv
// Shared types and reference semantics for the skolem_sweep controller.
//   - state_e   : sweep FSM states
//   - cls_e     : classification of one returned witness (bit index into a one-hot vector)
//   - lshr_ref  : logical shift right, 0 when the shift amount reaches the operand width
//   - ic_lshr_ne: invertibility condition of (x >> s) != t
// The reference functions work on OPW-bit zero-extended operands so that any W <= OPW can use them.
package skolem_sweep_pkg;

    localparam int W_DEF = 4;
    localparam int OPW   = 16;
    localparam int NCLS  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CLS_PASS = 2'd0,
        CLS_FAIL = 2'd1,
        CLS_SKIP = 2'd2
    } cls_e;

    function automatic logic [OPW-1:0] lshr_ref(input logic [OPW-1:0] x,
                                                input logic [OPW-1:0] s,
                                                input int             w);
        if (s >= OPW'(w)) begin
            return '0;
        end
        return x >> s;
    endfunction

    function automatic logic ic_lshr_ne(input logic [OPW-1:0] s,
                                        input logic [OPW-1:0] t,
                                        input int             w);
        return (s < OPW'(w)) || (t != '0);
    endfunction

endpackage

// File: rtl/skolem_sweep_check.sv
// Alignment and classification stage of the sweep controller.
// Delays each issued (s, t, valid) by CORE_LAT cycles so it meets the matching core_x,
// classifies the pair, and registers a one-hot class plus the classified pair.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   flush_i                 drop every in-flight pair (abort)
//   clr_i                   clear the class register (sweep start)
//   iss_vld_i/s_i/t_i       pair being issued to the core this cycle
//   core_x_i                witness from the core for the pair now at the end of the delay line
//   pend_o                  pairs still in flight that have not yet been sampled this cycle
//   cls_o                   registered one-hot class of the pair sampled last cycle
//   cap_s_o/t_o/x_o         that pair and its witness
module skolem_sweep_check
    import skolem_sweep_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int CORE_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            clr_i,
    input  logic            iss_vld_i,
    input  logic [W-1:0]    iss_s_i,
    input  logic [W-1:0]    iss_t_i,
    input  logic [W-1:0]    core_x_i,
    output logic            pend_o,
    output logic [NCLS-1:0] cls_o,
    output logic [W-1:0]    cap_s_o,
    output logic [W-1:0]    cap_t_o,
    output logic [W-1:0]    cap_x_o
);

    logic            smp_vld;
    logic [W-1:0]    smp_s;
    logic [W-1:0]    smp_t;
    logic            ic;
    logic            hit;
    logic [NCLS-1:0] cls_d;
    logic [NCLS-1:0] cls_q;
    logic [W-1:0]    cap_s_q;
    logic [W-1:0]    cap_t_q;
    logic [W-1:0]    cap_x_q;

    generate
        if (CORE_LAT == 0) begin : g_nodly
            assign smp_vld = iss_vld_i;
            assign smp_s   = iss_s_i;
            assign smp_t   = iss_t_i;
            assign pend_o  = 1'b0;
        end else begin : g_dly
            // stage 0 holds the pair issued last cycle; the last stage is being sampled now
            logic [CORE_LAT-1:0] vld_q;
            logic [W-1:0]        s_q [CORE_LAT];
            logic [W-1:0]        t_q [CORE_LAT];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vld_q <= '0;
                    for (int j = 0; j < CORE_LAT; j++) begin
                        s_q[j] <= '0;
                        t_q[j] <= '0;
                    end
                end else begin
                    for (int j = CORE_LAT - 1; j > 0; j--) begin
                        vld_q[j] <= vld_q[j-1] & ~flush_i;
                        s_q[j]   <= s_q[j-1];
                        t_q[j]   <= t_q[j-1];
                    end
                    vld_q[0] <= iss_vld_i & ~flush_i;
                    s_q[0]   <= iss_s_i;
                    t_q[0]   <= iss_t_i;
                end
            end

            assign smp_vld = vld_q[CORE_LAT-1];
            assign smp_s   = s_q[CORE_LAT-1];
            assign smp_t   = t_q[CORE_LAT-1];

            // the last stage is consumed this cycle, so it does not count as pending
            always_comb begin
                pend_o = 1'b0;
                for (int j = 0; j < CORE_LAT - 1; j++) begin
                    pend_o = pend_o | vld_q[j];
                end
            end
        end
    endgenerate

    always_comb begin
        ic    = ic_lshr_ne(OPW'(smp_s), OPW'(smp_t), W);
        hit   = (lshr_ref(OPW'(core_x_i), OPW'(smp_s), W) == OPW'(smp_t));
        cls_d = '0;
        if (smp_vld) begin
            if (!ic) begin
                cls_d[CLS_SKIP] = 1'b1;
            end else if (hit) begin
                cls_d[CLS_FAIL] = 1'b1;
            end else begin
                cls_d[CLS_PASS] = 1'b1;
            end
        end
    end

    // flush does not touch cls_q: the pair sampled in the abort cycle still counts
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cls_q   <= '0;
            cap_s_q <= '0;
            cap_t_q <= '0;
            cap_x_q <= '0;
        end else begin
            cls_q <= clr_i ? '0 : cls_d;
            if (smp_vld) begin
                cap_s_q <= smp_s;
                cap_t_q <= smp_t;
                cap_x_q <= core_x_i;
            end
        end
    end

    assign cls_o   = cls_q;
    assign cap_s_o = cap_s_q;
    assign cap_t_o = cap_t_q;
    assign cap_x_o = cap_x_q;

endmodule

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep controller for a W-bit bvlshr/ne Skolem-function core.
// Issues every (s, t) pair once, checks the returned witness and keeps pass/fail/skip
// counts plus the first failing pair.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   start_i, abort_i                 host handshake
//   busy_o, done_o                   sweep running / one-cycle completion pulse
//   core_vld_o, core_s_o, core_t_o   pair driven to the core
//   core_x_i                         witness from the core (CORE_LAT cycles later)
//   pass/fail/skip_cnt_o             classification counters
//   ff_vld_o, ff_s_o, ff_t_o, ff_x_o first failure record
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | one pair per cycle to the core
// DRAIN  | waiting for the last witnesses to be checked
// DONE   | results final, done pulse
module skolem_sweep_ctrl
    import skolem_sweep_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int CORE_LAT = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic           abort_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           core_vld_o,
    output logic [W-1:0]   core_s_o,
    output logic [W-1:0]   core_t_o,
    input  logic [W-1:0]   core_x_i,
    output logic [2*W:0]   pass_cnt_o,
    output logic [2*W:0]   fail_cnt_o,
    output logic [2*W:0]   skip_cnt_o,
    output logic           ff_vld_o,
    output logic [W-1:0]   ff_s_o,
    output logic [W-1:0]   ff_t_o,
    output logic [W-1:0]   ff_x_o
);

    localparam int IW = 2 * W;
    localparam int CW = 2 * W + 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ISSUE = ST_ISSUE;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   pass_q, fail_q, skip_q;
    logic            ff_vld_q;
    logic [W-1:0]    ff_s_q, ff_t_q, ff_x_q;

    logic            accept;
    logic            issuing;
    logic            last_idx;
    logic            pend;
    logic [NCLS-1:0] cls;
    logic [W-1:0]    cap_s, cap_t, cap_x;
    logic            new_ff;

    assign accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i && !abort_i;
    assign issuing  = (state_q == S_ISSUE);
    assign last_idx = (idx_q == '1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (last_idx) begin
                    // with no core latency the last pair is checked in its own issue cycle
                    state_d = (CORE_LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (!pend) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (accept) begin
            idx_d = '0;
        end else if (issuing) begin
            idx_d = idx_q + 1'b1;
        end
    end

    skolem_sweep_check #(
        .W        (W),
        .CORE_LAT (CORE_LAT)
    ) u_check (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (abort_i),
        .clr_i     (accept),
        .iss_vld_i (issuing),
        .iss_s_i   (core_s_o),
        .iss_t_i   (core_t_o),
        .core_x_i  (core_x_i),
        .pend_o    (pend),
        .cls_o     (cls),
        .cap_s_o   (cap_s),
        .cap_t_o   (cap_t),
        .cap_x_o   (cap_x)
    );

    assign new_ff = cls[CLS_FAIL] && !ff_vld_q;

    // the registered class is folded into the counters one cycle after it appears;
    // the outputs add it in so results are visible in the cycle after sampling
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            skip_q   <= '0;
            ff_vld_q <= 1'b0;
            ff_s_q   <= '0;
            ff_t_q   <= '0;
            ff_x_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                pass_q   <= '0;
                fail_q   <= '0;
                skip_q   <= '0;
                ff_vld_q <= 1'b0;
                ff_s_q   <= '0;
                ff_t_q   <= '0;
                ff_x_q   <= '0;
            end else begin
                pass_q <= pass_q + CW'(cls[CLS_PASS]);
                fail_q <= fail_q + CW'(cls[CLS_FAIL]);
                skip_q <= skip_q + CW'(cls[CLS_SKIP]);
                if (new_ff) begin
                    ff_vld_q <= 1'b1;
                    ff_s_q   <= cap_s;
                    ff_t_q   <= cap_t;
                    ff_x_q   <= cap_x;
                end
            end
        end
    end

    assign busy_o     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done_o     = (state_q == S_DONE);
    assign core_vld_o = issuing;
    assign core_s_o   = issuing ? idx_q[IW-1:W] : '0;
    assign core_t_o   = issuing ? idx_q[W-1:0]  : '0;

    assign pass_cnt_o = pass_q + CW'(cls[CLS_PASS]);
    assign fail_cnt_o = fail_q + CW'(cls[CLS_FAIL]);
    assign skip_cnt_o = skip_q + CW'(cls[CLS_SKIP]);
    assign ff_vld_o   = ff_vld_q | cls[CLS_FAIL];
    assign ff_s_o     = new_ff ? cap_s : ff_s_q;
    assign ff_t_o     = new_ff ? cap_t : ff_t_q;
    assign ff_x_o     = new_ff ? cap_x : ff_x_q;

endmodule

// File: doc/skolem_sweep_ctrl.md
# skolem_sweep_ctrl

Sequencing controller that exhaustively drives an external 4-bit Skolem-function core for the bvlshr/ne invertibility problem and checks every witness it returns. For each input pair (s, t) it issues the pair to the core, captures the produced x, and classifies the pair as pass, fail or skip. A pair is a pass when (x >> s) != t, and a skip when no witness exists. The block sits between a test/config host (start/abort handshake, result registers) and the combinational or pipelined Skolem core under evaluation.

## Interface
- W, 4, operand width; s, t and x are W bits wide and 2^(2W) pairs are swept
- CORE_LAT, 1, number of cycles from core_s/core_t being driven to core_x being valid; range 0..7
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  start a sweep; sampled only in IDLE or DONE
- abort  in  1  kill a running sweep
- busy  out  1  high in ISSUE and DRAIN
- done  out  1  one-cycle pulse; all counters are final in this cycle
- core_vld  out  1  high while core_s/core_t carry an issued pair
- core_s  out  W  shift operand driven to the core
- core_t  out  W  target operand driven to the core
- core_x  in  W  witness returned by the core
- pass_cnt, fail_cnt, skip_cnt  out  2W+1 each  classification counters
- ff_vld  out  1  a failure has been recorded
- ff_s, ff_t, ff_x  out  W each  first failing pair and the witness the core returned for it

## Operation
- States and transitions:
  - IDLE to ISSUE on start & ~abort.
  - ISSUE to DRAIN after idx 2^(2W)-1 has been issued.
  - DRAIN to DONE when the check pipeline is empty.
  - DONE to IDLE after one cycle; start in DONE goes directly to ISSUE.
  - Any state to IDLE on abort, except IDLE, where abort only blocks start.
- Pair generation:
  - idx counter is 2W bits wide; s = idx[2W-1:W], t = idx[W-1:0].
  - One pair is issued per ISSUE cycle, with no stalls.
- Reference semantics:
  - lshr(x, s) = x >> s, and equals 0 when s >= W.
  - Invertibility condition ic = (s < W) | (t != 0).
- Classification of a returned core_x:
  - ~ic: skip. x is ignored.
  - ic & (lshr(x, s) != t): pass.
  - ic & (lshr(x, s) == t): fail.
- First failure: the first fail in sweep order loads ff_s, ff_t, ff_x and sets ff_vld. Later fails do not overwrite these registers.
- Sweep start: all counters, ff_vld and ff_* clear to 0 in the cycle the start is accepted.
- In-flight tracking: s and t are delayed CORE_LAT stages alongside a valid bit so they line up with core_x.
- Abort behaviour:
  - All in-flight valid bits are cleared, so no further counter updates occur.
  - Counters hold their partial values.
  - done is not pulsed.
- start while busy is ignored.
- Invariant at done: pass_cnt + fail_cnt + skip_cnt = 2^(2W).

## Timing
- Cycle 0: start accepted.
- Cycles 1..256: ISSUE, with idx = 0..255. core_vld is high during these cycles.
- Core sampling: the pair issued at cycle k is sampled from core_x at cycle k+CORE_LAT.
- Counter/ff register update is visible at cycle k+CORE_LAT+1.
- done pulses at cycle 257+CORE_LAT; busy falls in the same cycle.
- Outside ISSUE: core_s, core_t and core_vld are 0.
- Reset values: every output is 0; the state is IDLE.
- Reset asserted mid-sweep: all state is lost immediately; no done.
- abort at cycle a while busy: busy is low from a+1; counters freeze at values that include only pairs whose checks completed by cycle a.
- Counter width 2W+1 holds 256 without wrap; idx wraps only at the ISSUE to DRAIN transition.

## Structure
- Package skolem_sweep_pkg holds:
  - the state enum (IDLE, ISSUE, DRAIN, DONE)
  - default W
  - function lshr_ref(x, s)
  - function ic_lshr_ne(s, t)
  - the class enum (PASS, FAIL, SKIP)
- Sub-module skolem_sweep_check holds:
  - the CORE_LAT alignment delay line (s, t, valid)
  - combinational classification
  - a registered one-hot class output feeding the counters in the parent

## Test plan
- Ideal core (returns a correct witness whenever ic holds), CORE_LAT=1 -> done at cycle 258; pass=244, fail=0, skip=12, ff_vld=0.
- Core stuck at x=0, CORE_LAT=1 -> pass=240, fail=4, skip=12; ff_vld=1, ff_s=0, ff_t=0, ff_x=0.
- Ideal core with CORE_LAT=0 and CORE_LAT=3 -> done at cycles 257 and 260; core_vld is high for exactly 256 cycles.
- abort at cycle 100, CORE_LAT=1 -> busy low at 101, no done; pass+fail+skip = 99, and counts stay frozen for 50 further cycles.
- start at cycle 50 mid-sweep -> ignored, sweep completes normally. After done, a new start clears counters to 0 at acceptance and the rerun gives identical totals.
- rst asserted at cycle 120 for 2 cycles -> all outputs 0 and state IDLE during reset. A following start produces a full, correct sweep.
